// File: rtl/rst_gen_pkg.sv
// Shared types and defaults for the reset pulse generator.
// State and cause encodings are fixed so they read the same in waveforms and firmware.
package rst_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ASSERT   = 2'd2,
    HOLDOFF  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_SW  = 2'b10
  } cause_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_ASSERT_CYCLES   = 16;
  localparam int DEF_HOLDOFF_CYCLES  = 8;
  localparam int DEF_SYNC_STAGES     = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so an idle-high input can come out of reset inactive.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_pulse_gen.sv
// Reset source: merges power-on, debounced button and software requests into one
// fixed-width active-low pulse with a hold-off window. Define RST_PULSE_GEN_CAUSE_EN for o_rst_cause.
module rst_pulse_gen
  import rst_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ASSERT_CYCLES   = DEF_ASSERT_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_rst_n,
  input  logic       i_sw_req,
  output logic       o_rst_n,
  output logic       o_busy,
  output logic       o_rst_done
`ifdef RST_PULSE_GEN_CAUSE_EN
  ,
  output logic [1:0] o_rst_cause
`endif
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, ASSERT_CYCLES, HOLDOFF_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Thresholds are "last cycle" values: the count includes the cycle being evaluated.
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rst_n_q, rst_n_d;
  logic             rst_done_q, rst_done_d;
  logic             btn_sync;

  bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_btn_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst),
    .i_d     (i_btn_rst_n),
    .o_q     (btn_sync)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      rst_n_q    <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_n_q    <= rst_n_d;
      rst_done_q <= rst_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (i_sw_req) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (!btn_sync) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d = ASSERT;
            cnt_d   = '0;
          end else begin
            state_d = DEBOUNCE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DEBOUNCE: begin
        if (i_sw_req || (!btn_sync && cnt_q >= DEB_LAST)) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ASSERT: begin
        if (cnt_q >= ASSERT_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLDOFF: begin
        // A button still held down keeps us here, so it cannot retrigger.
        if (cnt_q >= HOLD_LAST && btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
    rst_n_d    = (state_d != ASSERT);
    rst_done_d = (state_q == ASSERT) && (state_d == HOLDOFF);
  end

  assign o_rst_n    = rst_n_q;
  assign o_rst_done = rst_done_q;
  assign o_busy     = (state_q != IDLE);

`ifdef RST_PULSE_GEN_CAUSE_EN
  logic [1:0] cause_q;

  // Entry to ASSERT only happens from IDLE/DEBOUNCE, where software has priority.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cause_q <= CAUSE_POR;
    end else if (state_d == ASSERT && state_q != ASSERT) begin
      cause_q <= i_sw_req ? CAUSE_SW : CAUSE_BTN;
    end
  end

  assign o_rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Directed bench for rst_pulse_gen: power-on, software, button, glitch, dropped requests, mid-pulse reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_rst_pulse_gen;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic btn_n  = 1'b1;
  logic sw_req = 1'b0;
  logic rst_n_o, busy, done;
`ifdef RST_PULSE_GEN_CAUSE_EN
  logic [1:0] cause;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rst_pulse_gen dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_btn_rst_n (btn_n),
    .i_sw_req    (sw_req),
    .o_rst_n     (rst_n_o),
    .o_busy      (busy),
    .o_rst_done  (done)
`ifdef RST_PULSE_GEN_CAUSE_EN
    ,
    .o_rst_cause (cause)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cause(input string tag, input logic [1:0] exp);
`ifdef RST_PULSE_GEN_CAUSE_EN
    check(tag, 32'(cause), 32'(exp));
`else
    if (exp === 2'bxx) $display("unreachable %s", tag);
`endif
  endtask

  // Counts falling-edge samples while o_rst_n is low, starting at the current one.
  task automatic count_low(output int n);
    n = 0;
    while (rst_n_o === 1'b0 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Counts busy samples and o_rst_done pulses from the first hold-off cycle onward.
  task automatic count_holdoff(output int nb, output int nd);
    nb = 0;
    nd = 0;
    while (busy === 1'b1 && nb < 64) begin
      if (done === 1'b1) nd++;
      nb++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, nd, k, lows, busys, dones;

    // 1. Power-on
    repeat (3) @(negedge clk);
    check("por_rst_n", 32'(rst_n_o), 32'd0);
    check("por_busy", 32'(busy), 32'd1);
    check("por_done", 32'(done), 32'd0);
    check_cause("por_cause", 2'b00);
    rst = 1'b1;
    count_low(n);
    check("por_low_len", n, 16);
    check("por_done_first", 32'(done), 32'd1);
    count_holdoff(nb, nd);
    check("por_holdoff_len", nb, 8);
    check("por_done_cnt", nd, 1);
    check("por_idle_rst_n", 32'(rst_n_o), 32'd1);
    $display("tx power_on: low=%0d holdoff=%0d done=%0d", n, nb, nd);

    // 2. Software pulse
    repeat (3) @(negedge clk);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    count_low(n);
    check("sw_low_len", n, 16);
    count_holdoff(nb, nd);
    check("sw_holdoff_len", nb, 8);
    check("sw_done_cnt", nd, 1);
    check_cause("sw_cause", 2'b10);
    $display("tx sw_req: low=%0d holdoff=%0d done=%0d", n, nb, nd);

    // 3. Button held low for ten sampled edges
    repeat (3) @(negedge clk);
    btn_n = 1'b0;
    fork
      begin
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
      end
    join_none
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (rst_n_o === 1'b0) break;
    end
    check("btn_latency", k, 6);
    count_low(n);
    check("btn_low_len", n, 16);
    count_holdoff(nb, nd);
    check("btn_holdoff_len", nb, 8);
    check("btn_done_cnt", nd, 1);
    check_cause("btn_cause", 2'b01);
    lows = 0;
    busys = 0;
    repeat (12) begin
      @(negedge clk);
      if (rst_n_o === 1'b0) lows++;
      if (busy === 1'b1) busys++;
    end
    check("btn_no_retrig_low", lows, 0);
    check("btn_no_retrig_busy", busys, 0);
    $display("tx button: latency=%0d low=%0d holdoff=%0d", k, n, nb);

    // 4. Button glitch of three samples
    btn_n = 1'b0;
    lows = 0;
    busys = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rst_n_o === 1'b0) lows++;
      if (busy === 1'b1) busys++;
      if (c == 3) btn_n = 1'b1;
    end
    check("glitch_low", lows, 0);
    check("glitch_busy", busys, 3);
    check_cause("glitch_cause", 2'b01);
    $display("tx glitch: busy=%0d low=%0d", busys, lows);

    // 5. Requests dropped in ASSERT and HOLDOFF; held button extends hold-off
    sw_req = 1'b1;
    lows = 0;
    busys = 0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rst_n_o === 1'b0) lows++;
      if (busy === 1'b1) busys++;
      if (done === 1'b1) dones++;
      sw_req = (c == 5) || (c == 18);
      if (c == 10) btn_n = 1'b0;
      if (c == 30) btn_n = 1'b1;
    end
    check("drop_low", lows, 16);
    check("drop_busy", busys, 32);
    check("drop_done", dones, 1);
    check("drop_idle", 32'(busy), 32'd0);
    check_cause("drop_cause", 2'b10);
    $display("tx dropped_reqs: low=%0d busy=%0d done=%0d", lows, busys, dones);

    // 6. Reset during ASSERT restarts a full pulse
    repeat (3) @(negedge clk);
    sw_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      sw_req = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_rst_n", 32'(rst_n_o), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check_cause("mid_rst_cause_async", 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_low(n);
    check("mid_rst_low_len", n, 16);
    count_holdoff(nb, nd);
    check("mid_rst_holdoff_len", nb, 8);
    check("mid_rst_done_cnt", nd, 1);
    check_cause("mid_rst_cause", 2'b00);
    $display("tx mid_reset: low=%0d holdoff=%0d done=%0d", n, nb, nd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
